// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file read/write/reserve bus with master and slave views
interface regfile_sb_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRW     = 5
);
  logic                 ready;
  logic [ADDRW-1:0]     readReg1;
  logic [ADDRW-1:0]     readReg2;
  logic [DATAWIDTH-1:0] readData1;
  logic [DATAWIDTH-1:0] readData2;
  logic                 readValid1;
  logic                 readValid2;
  logic [ADDRW-1:0]     writeReg;
  logic [DATAWIDTH-1:0] writeData;
  logic                 write;
  logic                 reserve;
  logic [ADDRW-1:0]     reserveReg;

  modport master (
    input  ready, readData1, readData2, readValid1, readValid2,
    output readReg1, readReg2, writeReg, writeData, write, reserve, reserveReg
  );

  modport slave (
    output ready, readData1, readData2, readValid1, readValid2,
    input  readReg1, readReg2, writeReg, writeData, write, reserve, reserveReg
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-bit scoreboard and sequential clear after reset
module regfile_sb #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_REG  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  regfile_sb_if.slave bus
);
  localparam int ADDRW = $clog2(NUM_REGS);
  // one extra bit so the range check also works when NUM_REGS is a power of two
  localparam logic [ADDRW:0]   NREGS = (ADDRW + 1)'(NUM_REGS);
  localparam logic [ADDRW-1:0] LAST  = ADDRW'(NUM_REGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDRW-1:0]      ptr;
  logic                  ready_q;
  logic [NUM_REGS-1:0]   pending;
  logic [DATAWIDTH-1:0]  regs [NUM_REGS];
  logic                  write_ok;
  logic                  reserve_ok;

  function automatic logic in_range(input logic [ADDRW-1:0] a);
    return ({1'b0, a} < NREGS);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDRW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // An accepted target must exist and must not be the hardwired zero register
  function automatic logic target_ok(input logic [ADDRW-1:0] a);
    return in_range(a) && !is_zero_reg(a);
  endfunction

  assign write_ok   = (state == RUN) && bus.write   && target_ok(bus.writeReg);
  assign reserve_ok = (state == RUN) && bus.reserve && target_ok(bus.reserveReg);
  assign bus.ready  = ready_q;

  // Read port result packed as {valid, data}; bypass beats the array but not the zero register
  function automatic logic [DATAWIDTH:0] read_port(input logic [ADDRW-1:0] a);
    logic [DATAWIDTH:0] r;
    r = '0;
    if (state == RUN) begin
      if (!in_range(a))
        r = '0;
      else if (is_zero_reg(a))
        r = {1'b1, {DATAWIDTH{1'b0}}};
      else if (write_ok && (bus.writeReg == a))
        r = {1'b1, bus.writeData};
      else
        r = {~pending[a], regs[a]};
    end
    return r;
  endfunction

  // Control FSM: reset restarts the clear walk, RUN maintains the scoreboard
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= CLEAR;
      ptr     <= '0;
      pending <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          // reserve is applied last so it wins over a same-edge write to the same register
          if (write_ok)
            pending[bus.writeReg] <= 1'b0;
          if (reserve_ok)
            pending[bus.reserveReg] <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage array: zeroed one entry per cycle during clear, written normally afterwards
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == CLEAR)
        regs[ptr] <= '0;
      else if (write_ok)
        regs[bus.writeReg] <= bus.writeData;
    end
  end

  // Two independent combinational read ports
  always_comb begin
    {bus.readValid1, bus.readData1} = read_port(bus.readReg1);
    {bus.readValid2, bus.readData2} = read_port(bus.readReg2);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb across three parameter sets
module tb_regfile_sb;
  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  rsvr;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] d1;
    logic        v1;
    logic [31:0] d2;
    logic        v2;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rr1, rr2, wr, rsvr;
  logic [31:0] wd;
  logic        we, rsv;
  int          total = 0;
  int          bad = 0;
  int          ea, eb, ec;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  regfile_sb_if #(.DATAWIDTH(32), .ADDRW(5)) if_a ();
  regfile_sb_if #(.DATAWIDTH(32), .ADDRW(5)) if_b ();
  regfile_sb_if #(.DATAWIDTH(32), .ADDRW(5)) if_c ();

  assign if_a.readReg1 = rr1;  assign if_b.readReg1 = rr1;  assign if_c.readReg1 = rr1;
  assign if_a.readReg2 = rr2;  assign if_b.readReg2 = rr2;  assign if_c.readReg2 = rr2;
  assign if_a.writeReg = wr;   assign if_b.writeReg = wr;   assign if_c.writeReg = wr;
  assign if_a.writeData = wd;  assign if_b.writeData = wd;  assign if_c.writeData = wd;
  assign if_a.write = we;      assign if_b.write = we;      assign if_c.write = we;
  assign if_a.reserve = rsv;   assign if_b.reserve = rsv;   assign if_c.reserve = rsv;
  assign if_a.reserveReg = rsvr; assign if_b.reserveReg = rsvr; assign if_c.reserveReg = rsvr;

  regfile_sb #(.DATAWIDTH(32), .NUM_REGS(32), .ZERO_REG(1)) dut_a (.clk(clk), .resetn(resetn), .bus(if_a));
  regfile_sb #(.DATAWIDTH(32), .NUM_REGS(32), .ZERO_REG(0)) dut_b (.clk(clk), .resetn(resetn), .bus(if_b));
  regfile_sb #(.DATAWIDTH(32), .NUM_REGS(24), .ZERO_REG(1)) dut_c (.clk(clk), .resetn(resetn), .bus(if_c));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    rsv = 1'b0;
  endtask

  task automatic add(input int a_we, input int a_wr, input logic [31:0] a_wd, input int a_rsv,
                     input int a_rsvr, input int a_rr1, input int a_rr2, input logic [31:0] a_d1,
                     input int a_v1, input logic [31:0] a_d2, input int a_v2);
    vec_t v;
    v.we = 1'(a_we);   v.wr = 5'(a_wr);     v.wd = a_wd;
    v.rsv = 1'(a_rsv); v.rsvr = 5'(a_rsvr);
    v.rr1 = 5'(a_rr1); v.rr2 = 5'(a_rr2);
    v.d1 = a_d1; v.v1 = 1'(a_v1); v.d2 = a_d2; v.v2 = 1'(a_v2);
    vecs.push_back(v);
  endtask

  initial begin
    // we wr wd rsv rsvr rr1 rr2 | d1 v1 d2 v2   (dut_a: 32 regs, zero register on)
    add(1,  5, 32'hDEADBEEF, 0, 0,  5,  5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
    add(0,  0, 32'h0,        0, 0,  5,  0, 32'hDEADBEEF, 1, 32'h0,        1);
    add(1,  0, 32'h1234,     1, 0,  0,  0, 32'h0,        1, 32'h0,        1);
    add(0,  0, 32'h0,        0, 0,  0,  5, 32'h0,        1, 32'hDEADBEEF, 1);
    add(0,  0, 32'h0,        1, 7,  7,  5, 32'h0,        1, 32'hDEADBEEF, 1);
    add(0,  0, 32'h0,        0, 0,  7,  7, 32'h0,        0, 32'h0,        0);
    add(1,  7, 32'h55,       0, 0,  7,  5, 32'h55,       1, 32'hDEADBEEF, 1);
    add(0,  0, 32'h0,        0, 0,  7,  7, 32'h55,       1, 32'h55,       1);
    add(1,  7, 32'hAA,       1, 7,  7,  3, 32'hAA,       1, 32'h0,        1);
    add(0,  0, 32'h0,        0, 0,  7,  7, 32'hAA,       0, 32'hAA,       0);
    add(0,  0, 32'h0,        1, 7,  7,  7, 32'hAA,       0, 32'hAA,       0);
    add(0,  0, 32'h0,        0, 0,  7,  7, 32'hAA,       0, 32'hAA,       0);
    add(1, 31, 32'hCAFEF00D, 0, 0, 31,  9, 32'hCAFEF00D, 1, 32'h0,        1);
    add(0,  0, 32'h0,        0, 0, 31,  7, 32'hCAFEF00D, 1, 32'hAA,       0);
    add(1,  7, 32'h77,       0, 0,  3,  7, 32'h0,        1, 32'h77,       1);
    add(0,  0, 32'h0,        0, 0,  7,  7, 32'h77,       1, 32'h77,       1);

    resetn = 1'b0;
    idle();
    rr1 = '0; rr2 = '0; wr = '0; wd = '0; rsvr = '0;
    repeat (3) tick();
    chk("reset_ready_a", 32'(if_a.ready), 32'd0);
    chk("reset_ready_c", 32'(if_c.ready), 32'd0);
    chk("reset_data1_a", if_a.readData1, 32'h0);
    chk("reset_valid1_a", 32'(if_a.readValid1), 32'd0);

    // start a clear, then restart it with a one-cycle reset pulse at edge 10
    resetn = 1'b1;
    repeat (10) tick();
    chk("midclear_ready_a", 32'(if_a.ready), 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;

    // write and reserve register 3 while still clearing: both must be ignored
    we = 1'b1; wr = 5'd3; wd = 32'hFF; rsv = 1'b1; rsvr = 5'd3; rr1 = 5'd3; rr2 = 5'd3;
    ea = -1; eb = -1; ec = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) begin
        chk("clear_data1_a", if_a.readData1, 32'h0);
        chk("clear_valid1_a", 32'(if_a.readValid1), 32'd0);
      end
      if (n == 6) idle();
      if (ea < 0 && if_a.ready) ea = n;
      if (eb < 0 && if_b.ready) eb = n;
      if (ec < 0 && if_c.ready) ec = n;
      if (ea >= 0 && eb >= 0 && ec >= 0) break;
    end
    idle();
    chk("clear_edges_a", 32'(ea), 32'd32);
    chk("clear_edges_b", 32'(eb), 32'd32);
    chk("clear_edges_c", 32'(ec), 32'd24);

    // every register of dut_a reads zero and valid after the clear
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i);
      rr2 = 5'(31 - i);
      #1;
      chk($sformatf("cleared_d1_r%0d", i), if_a.readData1, 32'h0);
      chk($sformatf("cleared_v1_r%0d", i), 32'(if_a.readValid1), 32'd1);
      chk($sformatf("cleared_v2_r%0d", 31 - i), 32'(if_a.readValid2), 32'd1);
    end
    rr1 = 5'd3;
    #1;
    chk("ignored_reg3_data_b", if_b.readData1, 32'h0);
    chk("ignored_reg3_valid_b", 32'(if_b.readValid1), 32'd1);
    tick();

    for (int k = 0; k < vecs.size(); k++) begin
      we = vecs[k].we; wr = vecs[k].wr; wd = vecs[k].wd;
      rsv = vecs[k].rsv; rsvr = vecs[k].rsvr;
      rr1 = vecs[k].rr1; rr2 = vecs[k].rr2;
      #3;
      chk($sformatf("vec%0d_d1", k), if_a.readData1, vecs[k].d1);
      chk($sformatf("vec%0d_v1", k), 32'(if_a.readValid1), 32'(vecs[k].v1));
      chk($sformatf("vec%0d_d2", k), if_a.readData2, vecs[k].d2);
      chk($sformatf("vec%0d_v2", k), 32'(if_a.readValid2), 32'(vecs[k].v2));
      tick();
    end

    // without a zero register, reg 0 kept 0x1234 and stays pending from the same-edge reserve
    idle();
    rr1 = 5'd0;
    #3;
    chk("nozero_reg0_data_b", if_b.readData1, 32'h1234);
    chk("nozero_reg0_valid_b", 32'(if_b.readValid1), 32'd0);
    chk("zero_reg0_data_a", if_a.readData1, 32'h0);
    chk("zero_reg0_valid_a", 32'(if_a.readValid1), 32'd1);
    tick();

    // out-of-range address on the 24-register instance
    we = 1'b1; wr = 5'd30; wd = 32'hFFFF0000; rr1 = 5'd30; rr2 = 5'd31;
    #3;
    chk("oor_bypass_data_c", if_c.readData1, 32'h0);
    chk("oor_bypass_valid_c", 32'(if_c.readValid1), 32'd0);
    chk("inrange_bypass_data_a", if_a.readData1, 32'hFFFF0000);
    tick();
    idle();
    #3;
    chk("oor_data_c", if_c.readData1, 32'h0);
    chk("oor_valid_c", 32'(if_c.readValid1), 32'd0);
    chk("oor_r31_valid_c", 32'(if_c.readValid2), 32'd0);
    chk("inrange_data_a", if_a.readData1, 32'hFFFF0000);
    chk("inrange_valid_a", 32'(if_a.readValid1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
